// File: rtl/sseg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with shadow register and active-low outputs.
// Optional leading-zero blanking is enabled by defining SSEG_LZB_EN.
module sseg_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [4*DIGITS-1:0]                   value,
    input  logic                                  load,
    output logic [6:0]                            sseg,
    output logic [DIGITS-1:0]                     an,
    output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] idx
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);

    logic [4*DIGITS-1:0] shadow;
    logic [PW-1:0]       prescaler;
    logic [6:0]          sseg_next;
    logic [DIGITS-1:0]   an_next;
    logic [DIGITS-1:0]   blank;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
        end else if (load) begin
            shadow <= value;
        end
    end

    // An out-of-range idx (only reachable through upset) is pulled back to 0 at the next advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            idx       <= '0;
        end else if (prescaler == PRE_LAST) begin
            prescaler <= '0;
            if (idx >= IDX_LAST) begin
                idx <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

`ifdef SSEG_LZB_EN
    // Digit k is blank when it and every more significant nibble are zero; digit 0 always shows.
    always_comb begin
        logic zero_run;
        blank    = '0;
        zero_run = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run & (shadow[4*k +: 4] == 4'h0);
            blank[k] = zero_run;
        end
    end
`else
    assign blank = '0;
`endif

    always_comb begin
        sseg_next = 7'b1111111;
        an_next   = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k) && !blank[k]) begin
                sseg_next  = decode(shadow[4*k +: 4]);
                an_next[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sseg <= 7'b1111111;
            an   <= '1;
        end else begin
            sseg <= sseg_next;
            an   <= an_next;
        end
    end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Self-checking bench for sseg_scan_driver: directed scenarios plus random loads/resets,
// compared every cycle against a cycle-count based reference model.
module tb_sseg_scan_driver;

    localparam int D = 4;
    localparam int R = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic [6:0]  sseg;
    logic [3:0]  an;
    logic [1:0]  idx;

    int check_count = 0;
    int fail_count  = 0;

    // Model state: shadow contents and edges elapsed since reset was released.
    logic [15:0] m_shadow;
    int          m_cycles;

    logic [6:0] glyph [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    sseg_scan_driver #(.DIGITS(D), .REFRESH_DIV(R)) dut (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .load  (load),
        .sseg  (sseg),
        .an    (an),
        .idx   (idx)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [6:0] exp_sseg,
                               input logic [3:0] exp_an, input logic [1:0] exp_idx);
        check_count++;
        assert (sseg === exp_sseg) else begin
            fail_count++;
            $error("[TB] FAIL %s sseg: observed %b expected %b", tag, sseg, exp_sseg);
        end
        check_count++;
        assert (an === exp_an) else begin
            fail_count++;
            $error("[TB] FAIL %s an: observed %b expected %b", tag, an, exp_an);
        end
        check_count++;
        assert (idx === exp_idx) else begin
            fail_count++;
            $error("[TB] FAIL %s idx: observed %0d expected %0d", tag, idx, exp_idx);
        end
    endtask

    // One clock edge with the given inputs, then compare against the model.
    task automatic applyStimulus(input string tag, input logic r, input logic l, input logic [15:0] v);
        logic [6:0] e_sseg;
        logic [3:0] e_an;
        logic [1:0] e_idx;
        int         digit;
        logic [15:0] upper;
        rst   = r;
        load  = l;
        value = v;
        if (r) begin
            e_sseg = 7'b1111111;
            e_an   = 4'b1111;
            e_idx  = 2'd0;
        end else begin
            digit  = (m_cycles / R) % D;
            upper  = m_shadow >> (4 * digit);
            e_sseg = glyph[upper[3:0]];
            e_an   = 4'b1111 ^ 4'(1 << digit);
`ifdef SSEG_LZB_EN
            if (digit > 0 && upper == 16'h0) begin
                e_sseg = 7'b1111111;
                e_an   = 4'b1111;
            end
`endif
            e_idx = 2'(((m_cycles + 1) / R) % D);
        end
        @(posedge clk);
        if (r) begin
            m_shadow = 16'h0;
            m_cycles = 0;
        end else begin
            if (l) m_shadow = v;
            m_cycles++;
        end
        #1;
        checkOutput(tag, e_sseg, e_an, e_idx);
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        value    = 16'h0;
        m_shadow = 16'h0;
        m_cycles = 0;

        for (int i = 0; i < 3; i++) applyStimulus("reset", 1'b1, 1'b0, 16'hFFFF);
        applyStimulus("release", 1'b0, 1'b0, 16'h0);

        // Full scan, including frame wrap.
        applyStimulus("load_1A2F", 1'b0, 1'b1, 16'h1A2F);
        for (int i = 0; i < 20; i++) applyStimulus("full_scan", 1'b0, 1'b0, 16'hDEAD);

        // Mid-scan load while digit 2 is selected.
        while (((m_cycles + 1) / R) % D != 2) applyStimulus("seek2", 1'b0, 1'b0, 16'h0);
        applyStimulus("midload", 1'b0, 1'b1, 16'h0800);
        for (int i = 0; i < 12; i++) applyStimulus("after_midload", 1'b0, 1'b0, 16'h1234);

        // Reset at idx=3, prescaler=2.
        while (!((m_cycles / R) % D == 3 && m_cycles % R == 2))
            applyStimulus("seek3", 1'b0, 1'b0, 16'h0);
        applyStimulus("reset_mid", 1'b1, 1'b1, 16'hBEEF);
        for (int i = 0; i < 6; i++) applyStimulus("restart", 1'b0, 1'b0, 16'h0);

        // Leading-zero patterns.
        applyStimulus("load_0005", 1'b0, 1'b1, 16'h0005);
        for (int i = 0; i < 16; i++) applyStimulus("lzb_0005", 1'b0, 1'b0, 16'h0);
        applyStimulus("load_0000", 1'b0, 1'b1, 16'h0000);
        for (int i = 0; i < 16; i++) applyStimulus("lzb_0000", 1'b0, 1'b0, 16'h0);

        // Load held high: shadow follows value each cycle.
        for (int i = 0; i < 8; i++) applyStimulus("load_held", 1'b0, 1'b1, 16'($urandom));

        // Random loads with occasional resets.
        for (int i = 0; i < 300; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            if ($urandom_range(0, 3) == 0) v = v & 16'h00FF;
            applyStimulus("random", ($urandom_range(0, 59) == 0), ($urandom_range(0, 5) == 0), v);
        end

        $display("%0d/%0d checks passed", check_count - fail_count, check_count);
        $finish;
    end

endmodule
